sort_host: RTL and testbench

SORT_HOST -- requirements
Module: sort_host

---
 rtl/sort_host_if.sv | 25 ++
 rtl/sort_host.sv | 159 +++++++++++++++
 tb/tb_sort_host.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sort_host_if.sv
// Stream and sorter-bus signals of sort_host, bundled for the host (master) and its environment (slave).
interface sort_host_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       sort_wr;
    logic [2:0] sort_addr;
    logic [7:0] sort_datain;
    logic       sort_start;
    logic [7:0] sort_dataout;
    logic       sort_ready;

    modport master (
        input  in_valid, in_data, out_ready, sort_dataout, sort_ready,
        output in_ready, out_valid, out_data, sort_wr, sort_addr, sort_datain, sort_start
    );

    modport slave (
        output in_valid, in_data, out_ready, sort_dataout, sort_ready,
        input  in_ready, out_valid, out_data, sort_wr, sort_addr, sort_datain, sort_start
    );
endinterface

// File: rtl/sort_host.sv
// Host for an external 8-entry byte sorter: loads 8 upstream bytes, kicks the sort,
// then reads the sorted bytes back out in ascending order with a valid/ready handshake.
module sort_host #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        nrst,
    sort_host_if.master bus,
    output logic        busy
);
    localparam int LW = $clog2(RD_LAT + 2);

    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        KICK    = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        RD_WAIT = 3'd4,
        SEND    = 3'd5
    } state_t;

    state_t         state_reg;
    state_t         state_next;
    logic [2:0]     wcnt_reg;
    logic [2:0]     rcnt_reg;
    logic [LW-1:0]  lcnt_reg;
    logic [7:0]     out_data_reg;
    logic           out_valid_reg;

    logic           accept;
    logic           out_fire;
    logic           lat_done;

    assign accept   = (state_reg == LOAD) && bus.in_valid && bus.sort_ready;
    assign out_fire = (state_reg == SEND) && bus.out_ready;
    assign lat_done = (lcnt_reg == LW'(RD_LAT));

    // State register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg <= LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LOAD: begin
                if (accept && (wcnt_reg == 3'd7)) begin
                    state_next = KICK;
                end
            end
            KICK: begin
                state_next = WAIT_LO;
            end
            WAIT_LO: begin
                if (!bus.sort_ready) begin
                    state_next = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.sort_ready) begin
                    state_next = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (lat_done) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    state_next = (rcnt_reg == 3'd7) ? LOAD : RD_WAIT;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // Output logic; the write path is combinational so an accepted byte lands in the sorter the same cycle
    always_comb begin
        bus.in_ready    = 1'b0;
        bus.sort_wr     = 1'b0;
        bus.sort_addr   = 3'd0;
        bus.sort_datain = 8'd0;
        bus.sort_start  = 1'b0;
        busy            = (state_reg != LOAD);
        case (state_reg)
            LOAD: begin
                bus.in_ready  = bus.sort_ready;
                bus.sort_addr = wcnt_reg;
                if (accept) begin
                    bus.sort_wr     = 1'b1;
                    bus.sort_datain = bus.in_data;
                end
            end
            KICK: begin
                bus.sort_start = 1'b1;
            end
            RD_WAIT, SEND: begin
                bus.sort_addr = rcnt_reg;
            end
            default: begin
                bus.sort_addr = 3'd0;
            end
        endcase
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;

    // Counters and the output holding register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            wcnt_reg      <= 3'd0;
            rcnt_reg      <= 3'd0;
            lcnt_reg      <= '0;
            out_data_reg  <= 8'd0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                LOAD: begin
                    if (accept) begin
                        wcnt_reg <= wcnt_reg + 3'd1;
                    end
                end
                WAIT_HI: begin
                    if (bus.sort_ready) begin
                        rcnt_reg <= 3'd0;
                        lcnt_reg <= '0;
                    end
                end
                RD_WAIT: begin
                    if (lat_done) begin
                        out_data_reg  <= bus.sort_dataout;
                        out_valid_reg <= 1'b1;
                    end else begin
                        lcnt_reg <= lcnt_reg + LW'(1);
                    end
                end
                SEND: begin
                    if (out_fire) begin
                        out_valid_reg <= 1'b0;
                        rcnt_reg      <= rcnt_reg + 3'd1;
                        lcnt_reg      <= '0;
                    end
                end
                default: begin
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sort_host.sv
// Self-checking bench for sort_host with a behavioural 8-entry sorter attached to its sorter bus.
module tb_sort_host;
    localparam int RD_LAT = 2;

    typedef logic [7:0] arr8_t [8];
    typedef logic [7:0] q8_t [$];

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    logic busy;

    sort_host_if bus();

    sort_host #(.RD_LAT(RD_LAT)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Sorter model: registered read pipeline, ready drops after start and rises when sorted
    arr8_t      smem;
    logic [7:0] rpipe [RD_LAT];
    logic       s_ready  = 1'b1;
    int         s_cnt    = 0;
    logic       ext_busy = 1'b0;

    assign bus.sort_ready   = s_ready & ~ext_busy;
    assign bus.sort_dataout = rpipe[RD_LAT-1];

    function automatic arr8_t sort8(input arr8_t a);
        arr8_t r = a;
        logic [7:0] t;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 7 - i; j++)
                if (r[j] > r[j+1]) begin
                    t = r[j]; r[j] = r[j+1]; r[j+1] = t;
                end
        return r;
    endfunction

    always @(posedge clk) begin
        if (bus.sort_wr) smem[bus.sort_addr] <= bus.sort_datain;
        rpipe[0] <= smem[bus.sort_addr];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
        if (bus.sort_start) begin
            s_ready <= 1'b0;
            s_cnt   <= int'($urandom_range(2, 9));
        end else if (!s_ready) begin
            if (s_cnt == 0) begin
                smem    <= sort8(smem);
                s_ready <= 1'b1;
            end else begin
                s_cnt <= s_cnt - 1;
            end
        end
    end

    // Bus monitor
    int         wr_cnt, wr_busy, start_cnt, run_len, max_run, overlap, bad_datain, bad_kick_addr;
    logic [2:0] wr_addrs [$];

    always @(posedge clk) begin
        if (nrst) begin
            if (bus.sort_wr) begin
                wr_cnt++;
                wr_addrs.push_back(bus.sort_addr);
                if (busy) wr_busy++;
            end else if (bus.sort_datain !== 8'd0) begin
                bad_datain++;
            end
            if (bus.sort_start) begin
                start_cnt++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (bus.sort_addr !== 3'd0) bad_kick_addr++;
            end else begin
                run_len = 0;
            end
            if (bus.sort_start && bus.sort_wr) overlap++;
        end
    end

    task automatic clear_mon();
        wr_cnt = 0; wr_busy = 0; start_cnt = 0; run_len = 0; max_run = 0;
        overlap = 0; bad_datain = 0; bad_kick_addr = 0;
        wr_addrs.delete();
    endtask

    // Reference: a batch comes out as its 8 bytes in ascending order
    function automatic q8_t ref_sort(input arr8_t b);
        q8_t q;
        foreach (b[i]) q.push_back(b[i]);
        q.sort();
        return q;
    endfunction

    // gap: 0 = in_valid always high, 1 = toggles 1/0, 2 = random
    task automatic load_batch(input arr8_t b, input int n, input int gap, output bit to);
        int k = 0;
        int cyc = 0;
        while (k < n && cyc < 300) begin
            @(negedge clk);
            case (gap)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = (cyc % 2 == 0);
                default: bus.in_valid = 1'($urandom_range(0, 1));
            endcase
            bus.in_data = bus.in_valid ? b[k] : 8'($urandom);
            #1;
            if (bus.in_valid && bus.in_ready) k++;
            cyc++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        to = (k < n);
    endtask

    // bp: 0 = out_ready always high, 1 = random backpressure
    task automatic collect(input int n, input int bp, output q8_t q, output bit to,
                           output logic rdy_after, output logic busy_after);
        int cyc = 0;
        q = {};
        while (q.size() < n && cyc < 600) begin
            @(negedge clk);
            bus.out_ready = (bp == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            if (bus.out_valid && bus.out_ready) q.push_back(bus.out_data);
            cyc++;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        rdy_after  = bus.in_ready;
        busy_after = busy;
        to = (q.size() < n);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", bus.out_data); end
        checks++; if (bus.sort_start !== 1'b0) begin failures++; $display("FAIL reset_sort_start got=%0b exp=0", bus.sort_start); end
        checks++; if (bus.sort_wr !== 1'b0) begin failures++; $display("FAIL reset_sort_wr_idle got=%0b exp=0", bus.sort_wr); end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        #1;
        checks++; if (bus.sort_wr !== 1'b1 || bus.sort_addr !== 3'd0 || bus.sort_datain !== 8'hA5) begin
            failures++; $display("FAIL reset_wr_path got wr=%0b addr=%0d data=%0d exp wr=1 addr=0 data=165",
                                 bus.sort_wr, bus.sort_addr, bus.sort_datain);
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    endtask

    task automatic test_basic();
        arr8_t b = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd7, 8'd2, 8'd6, 8'd4};
        q8_t got, exp;
        bit to1, to2;
        logic ra, ba, v;
        clear_mon();
        load_batch(b, 8, 0, to1);
        collect(8, 0, got, to2, ra, ba);
        exp = ref_sort(b);
        checks++; if (to1 || to2) begin failures++; $display("FAIL basic_timeout got load=%0b out=%0b exp 0 0", to1, to2); end
        for (int i = 0; i < 8; i++) begin
            v = 1'b0;
            checks++;
            if (i >= got.size() || got[i] !== exp[i]) begin
                failures++; $display("FAIL basic_out[%0d] got=%0d exp=%0d", i, (i < got.size()) ? got[i] : 8'hxx, exp[i]);
            end
        end
        checks++; if (ba !== 1'b0 || ra !== 1'b1) begin failures++; $display("FAIL basic_idle got busy=%0b in_ready=%0b exp busy=0 in_ready=1", ba, ra); end
        checks++; if (bad_datain != 0 || bad_kick_addr != 0) begin failures++; $display("FAIL basic_bus_idle_values got datain=%0d addr=%0d exp 0 0", bad_datain, bad_kick_addr); end
    endtask

    task automatic test_dups();
        arr8_t b = '{8'd9, 8'd9, 8'd0, 8'd0, 8'd255, 8'd255, 8'd1, 8'd1};
        q8_t got, exp;
        bit to1, to2;
        logic ra, ba;
        load_batch(b, 8, 2, to1);
        collect(8, 1, got, to2, ra, ba);
        exp = ref_sort(b);
        checks++; if (to1 || to2 || got.size() != 8) begin failures++; $display("FAIL dups_count got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin failures++; $display("FAIL dups_out[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        arr8_t b = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd7, 8'd2, 8'd6, 8'd4};
        q8_t got, exp;
        bit to1;
        int stall = 0;
        int cyc = 0;
        load_batch(b, 8, 0, to1);
        exp = ref_sort(b);
        got = {};
        while (got.size() < 8 && cyc < 600) begin
            @(negedge clk);
            if (got.size() == 2 && bus.out_valid && stall < 3) begin
                bus.out_ready = 1'b0;
                #1;
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd3) begin
                    failures++; $display("FAIL bp_hold[%0d] got valid=%0b data=%0d exp valid=1 data=3", stall, bus.out_valid, bus.out_data);
                end
                stall++;
            end else begin
                bus.out_ready = 1'b1;
                #1;
                if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
            end
            cyc++;
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if (stall != 3 || got.size() != 8) begin failures++; $display("FAIL bp_count got stalls=%0d outs=%0d exp 3 8", stall, got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin failures++; $display("FAIL bp_out[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_gaps();
        arr8_t b;
        q8_t got, exp;
        bit to1, to2;
        logic ra, ba;
        foreach (b[i]) b[i] = 8'($urandom);
        clear_mon();
        load_batch(b, 8, 1, to1);
        collect(8, 0, got, to2, ra, ba);
        exp = ref_sort(b);
        checks++; if (wr_cnt != 8) begin failures++; $display("FAIL gaps_wr_count got=%0d exp=8", wr_cnt); end
        for (int i = 0; i < 8 && i < wr_addrs.size(); i++) begin
            checks++;
            if (wr_addrs[i] !== 3'(i)) begin failures++; $display("FAIL gaps_wr_addr[%0d] got=%0d exp=%0d", i, wr_addrs[i], i); end
        end
        checks++; if (start_cnt != 1 || max_run != 1) begin failures++; $display("FAIL gaps_start got pulses=%0d width=%0d exp 1 1", start_cnt, max_run); end
        checks++; if (overlap != 0) begin failures++; $display("FAIL gaps_start_wr_overlap got=%0d exp=0", overlap); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin failures++; $display("FAIL gaps_out[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_ignore_inputs();
        arr8_t b;
        q8_t got, exp;
        bit to1, to2;
        logic ra, ba;
        foreach (b[i]) b[i] = 8'($urandom);
        load_batch(b, 8, 0, to1);
        clear_mon();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hEE;
        collect(8, 1, got, to2, ra, ba);
        bus.in_valid = 1'b0;
        exp = ref_sort(b);
        checks++; if (wr_cnt != 0) begin failures++; $display("FAIL ignore_writes got=%0d exp=0", wr_cnt); end
        checks++; if (got.size() != 8) begin failures++; $display("FAIL ignore_count got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin failures++; $display("FAIL ignore_out[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_ext_busy();
        arr8_t b;
        q8_t got, exp;
        bit to1, to2;
        logic ra, ba;
        clear_mon();
        @(negedge clk);
        ext_busy     = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'($urandom);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (bus.in_ready !== 1'b0 || bus.sort_wr !== 1'b0) begin
                failures++; $display("FAIL ext_busy_stall[%0d] got in_ready=%0b sort_wr=%0b exp 0 0", i, bus.in_ready, bus.sort_wr);
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        ext_busy     = 1'b0;
        checks++; if (wr_cnt != 0) begin failures++; $display("FAIL ext_busy_writes got=%0d exp=0", wr_cnt); end
        foreach (b[i]) b[i] = 8'($urandom);
        load_batch(b, 8, 0, to1);
        collect(8, 0, got, to2, ra, ba);
        exp = ref_sort(b);
        checks++; if (wr_addrs.size() != 8 || wr_addrs[0] !== 3'd0) begin
            failures++; $display("FAIL ext_busy_first_addr got=%0d exp=0", (wr_addrs.size() > 0) ? wr_addrs[0] : 3'bxxx);
        end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin failures++; $display("FAIL ext_busy_out[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_reset_mid();
        arr8_t a;
        arr8_t b = '{8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
        arr8_t junk;
        q8_t got, exp;
        bit to1, to2;
        logic ra, ba;
        int cyc = 0;
        foreach (a[i]) a[i] = 8'($urandom);
        foreach (junk[i]) junk[i] = 8'($urandom);
        load_batch(a, 8, 2, to1);
        collect(4, 0, got, to2, ra, ba);
        exp = ref_sort(a);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin failures++; $display("FAIL rstmid_first[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
        end
        while (!bus.out_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_pending got=%0b exp=1", bus.out_valid); end
        #1 nrst = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_async got valid=%0b busy=%0b exp 0 0", bus.out_valid, busy);
        end
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        load_batch(junk, 3, 0, to1);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        clear_mon();
        load_batch(b, 8, 0, to1);
        collect(8, 0, got, to2, ra, ba);
        exp = ref_sort(b);
        for (int i = 0; i < 8 && i < wr_addrs.size(); i++) begin
            checks++;
            if (wr_addrs[i] !== 3'(i)) begin failures++; $display("FAIL rstmid_wr_addr[%0d] got=%0d exp=%0d", i, wr_addrs[i], i); end
        end
        checks++; if (got.size() != 8) begin failures++; $display("FAIL rstmid_count got=%0d exp=8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp[i]) begin failures++; $display("FAIL rstmid_out[%0d] got=%0d exp=%0d", i, got[i], exp[i]); end
        end
    endtask

    task automatic test_back_to_back();
        arr8_t b;
        q8_t got, exp;
        bit to1, to2;
        logic ra, ba;
        for (int bi = 0; bi < 5; bi++) begin
            foreach (b[i]) b[i] = (bi == 2) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            clear_mon();
            load_batch(b, 8, int'($urandom_range(0, 2)), to1);
            collect(8, 1, got, to2, ra, ba);
            exp = ref_sort(b);
            checks++; if (ra !== 1'b1 || got.size() != 8) begin
                failures++; $display("FAIL b2b[%0d]_ready_after got in_ready=%0b outs=%0d exp 1 8", bi, ra, got.size());
            end
            checks++; if (overlap != 0 || start_cnt != 1) begin
                failures++; $display("FAIL b2b[%0d]_start got pulses=%0d overlap=%0d exp 1 0", bi, start_cnt, overlap);
            end
            for (int i = 0; i < 8 && i < got.size(); i++) begin
                checks++;
                if (got[i] !== exp[i]) begin failures++; $display("FAIL b2b[%0d]_out[%0d] got=%0d exp=%0d", bi, i, got[i], exp[i]); end
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'd0;
        bus.out_ready = 1'b0;
        clear_mon();
        test_reset();
        test_basic();
        test_dups();
        test_backpressure();
        test_gaps();
        test_ignore_inputs();
        test_ext_busy();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
